// File: rtl/mips_multi_control.sv
// Multi-cycle MIPS control FSM: decodes Op/Funct, sequences instruction phases, drives ALU/datapath controls.
// Optional feature: define MCTRL_BNE_EN to accept bne (Op 000101) as a branch on ~Zero.
module mips_multi_control #(
  parameter int CNT_W    = 32,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic [3:0]       ALUControl,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             PCEn,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  state_t state, state_nx;

  function automatic logic funct_legal(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  logic ready, bne_op, taken;
  logic [3:0] alu_c;
  logic       srca_c, iord_c, memwr_c, irwr_c, regdst_c, memtoreg_c, regwr_c;
  logic       pcwrite_c, branch_c, illegal_c, retire_c;
  logic [1:0] srcb_c, pcsrc_c;

  assign ready = MEM_WAIT ? MemReady : 1'b1;

`ifdef MCTRL_BNE_EN
  assign bne_op = (Op == OP_BNE);
`else
  assign bne_op = 1'b0;
`endif

  // IR is loaded in FETCH, so Op/Funct stay valid for the rest of the instruction
  assign taken = bne_op ? ~Zero : Zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        InstrCount <= '0;
    else if (retire_c) InstrCount <= InstrCount + CNT_W'(1);
  end

  always_comb begin
    state_nx   = state;
    alu_c      = ALU_ADD;
    srca_c     = 1'b0;
    srcb_c     = 2'b00;
    pcsrc_c    = 2'b00;
    iord_c     = 1'b0;
    memwr_c    = 1'b0;
    irwr_c     = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwr_c    = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    illegal_c  = 1'b0;
    retire_c   = 1'b0;
    case (state)
      S_FETCH: begin
        srcb_c    = 2'b01;
        irwr_c    = ready;
        pcwrite_c = ready;
        if (ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        srcb_c = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = S_EXEC;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JUMP;
          default: begin
            if (bne_op) begin
              state_nx = S_BRANCH;
            end else begin
              illegal_c = 1'b1;
              state_nx  = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        srca_c   = 1'b1;
        srcb_c   = 2'b10;
        state_nx = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_c = 1'b1;
        if (ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwr_c    = 1'b1;
        retire_c   = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEMWR: begin
        // held steady while waiting so the memory sees a single write
        iord_c  = 1'b1;
        memwr_c = 1'b1;
        if (ready) begin
          retire_c = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_EXEC: begin
        srca_c    = 1'b1;
        alu_c     = funct_alu(Funct);
        illegal_c = ~funct_legal(Funct);
        state_nx  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst_c = 1'b1;
        regwr_c  = funct_legal(Funct);
        retire_c = funct_legal(Funct);
        state_nx = S_FETCH;
      end
      S_BRANCH: begin
        srca_c   = 1'b1;
        alu_c    = ALU_SUB;
        pcsrc_c  = 2'b01;
        branch_c = 1'b1;
        retire_c = 1'b1;
        state_nx = S_FETCH;
      end
      S_ADDIEX: begin
        srca_c   = 1'b1;
        srcb_c   = 2'b10;
        state_nx = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwr_c  = 1'b1;
        retire_c = 1'b1;
        state_nx = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_c   = 2'b10;
        pcwrite_c = 1'b1;
        retire_c  = 1'b1;
        state_nx  = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // Write enables and the fault pulse are gated by rst_n so an in-flight access dies at once
  assign ALUControl = alu_c;
  assign ALUSrcA    = srca_c;
  assign ALUSrcB    = srcb_c;
  assign PCSrc      = pcsrc_c;
  assign IorD       = iord_c;
  assign RegDst     = regdst_c;
  assign MemtoReg   = memtoreg_c;
  assign MemWrite   = rst_n & memwr_c;
  assign IRWrite    = rst_n & irwr_c;
  assign RegWrite   = rst_n & regwr_c;
  assign PCEn       = rst_n & (pcwrite_c | (branch_c & taken));
  assign Illegal    = rst_n & illegal_c;

endmodule
